store_rmw_ctrl: RTL and testbench

//  Sequences SW/SH/SB stores in the multicycle MIPS datapath. SW is a direct write;
//  SH/SB are read-modify-write: read the memory word, merge the low half/byte of B

---
 rtl/store_rmw_ctrl_pkg.sv | 25 ++
 rtl/store_rmw_ctrl_store_merge.sv | 27 ++
 rtl/store_rmw_ctrl.sv | 101 ++++++++++
 tb/tb_store_rmw_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_rmw_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_rmw_ctrl_pkg
//  Description : Store-op and store-sequencer state encodings shared by the
//                store controller, the merge unit and the main control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_rmw_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_SW  = 2'b01,
        OP_SH  = 2'b10,
        OP_SB  = 2'b11
    } store_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } store_state_e;

endpackage : store_rmw_ctrl_pkg
`default_nettype wire

// File: rtl/store_rmw_ctrl_store_merge.sv
`default_nettype none
// ============================================================================
//  Module      : store_merge
//  Description : Merges the low half/byte of B into a memory word (SH/SB);
//                SW and NOP pass B through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_merge
    import store_rmw_ctrl_pkg::*;
(
    input  store_op_e   i_op,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_b,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_b;
        case (i_op)
            OP_SH:   o_merged = {i_mem_word[31:16], i_b[15:0]};
            OP_SB:   o_merged = {i_mem_word[31:8],  i_b[7:0]};
            default: o_merged = i_b;
        endcase
    end

endmodule : store_merge
`default_nettype wire

// File: rtl/store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : store_rmw_ctrl
//  Description : SW/SH/SB store sequencer for the multicycle datapath. SW is a
//                direct write; SH/SB read the word, merge, then write back.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_rmw_ctrl
    import store_rmw_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  store_op,
    input  logic [31:0] addr_in,
    input  logic [31:0] b_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_reg_q,
    output logic        busy,
    output logic        done
);

    localparam int               c_CNT_W    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_LAT_LOAD = c_CNT_W'(MEM_LAT);

    store_state_e       r_state;
    store_op_e          r_op;
    logic [31:0]        r_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [31:0]        r_mem_reg_q;
    logic [31:0]        w_merged;

    store_merge u_store_merge (
        .i_op       (r_op),
        .i_mem_word (mem_rdata),
        .i_b        (r_b),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_NOP;
            r_b         <= '0;
            r_cnt       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_reg_q <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op       <= store_op_e'(store_op);
                        r_b        <= b_in;
                        r_mem_addr <= addr_in;
                        case (store_op_e'(store_op))
                            OP_SW: begin
                                r_mem_wdata <= b_in;
                                r_state     <= ST_WRITE;
                            end
                            OP_SH, OP_SB: begin
                                r_cnt   <= c_LAT_LOAD;
                                r_state <= ST_READ;
                            end
                            default: r_state <= ST_DONE;
                        endcase
                    end
                end
                ST_READ: begin
                    // mem_rdata is valid only in the last READ cycle (counter at zero)
                    if (r_cnt == '0) begin
                        r_mem_reg_q <= mem_rdata;
                        r_mem_wdata <= w_merged;
                        r_state     <= ST_WRITE;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                ST_WRITE: r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Gating with reset suppresses a write or done pulse in the cycle reset lands
    assign mem_wr    = (r_state == ST_WRITE) && !reset;
    assign done      = (r_state == ST_DONE)  && !reset;
    assign busy      = (r_state != ST_IDLE);
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_reg_q = r_mem_reg_q;

endmodule : store_rmw_ctrl
`default_nettype wire

// File: tb/tb_store_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_rmw_ctrl
//  Description : Scoreboard bench for store_rmw_ctrl (MEM_LAT=1 and MEM_LAT=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_rmw_ctrl;

    typedef struct { int d; logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int d; int cyc; logic [31:0] regq; } dn_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       reset_v, start_v, wr_v, busy_v, done_v;
    logic [1:0][1:0]  op_v;
    logic [1:0][31:0] addr_v, b_v, rdata_v, maddr_v, wdata_v, regq_v;

    logic [31:0]      rd0;
    logic [2:0][31:0] rd1;
    assign rdata_v[0] = rd0;
    assign rdata_v[1] = rd1[2];

    store_rmw_ctrl #(.MEM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .store_op(op_v[0]),
        .addr_in(addr_v[0]), .b_in(b_v[0]), .mem_rdata(rdata_v[0]),
        .mem_addr(maddr_v[0]), .mem_wr(wr_v[0]), .mem_wdata(wdata_v[0]),
        .mem_reg_q(regq_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    store_rmw_ctrl #(.MEM_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .store_op(op_v[1]),
        .addr_in(addr_v[1]), .b_in(b_v[1]), .mem_rdata(rdata_v[1]),
        .mem_addr(maddr_v[1]), .mem_wr(wr_v[1]), .mem_wdata(wdata_v[1]),
        .mem_reg_q(regq_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    function automatic logic [31:0] seed_word(input int d, input int i);
        return (32'(i + 1) * 32'h9E3779B1) ^ ((d == 1) ? 32'h5A5A0F0F : 32'h0);
    endfunction

    // Memory that answers the DUTs: MEM_LAT-deep read pipeline per DUT
    logic [31:0] sim_mem [2][64];
    logic        mem_init, poke_en;
    int          poke_d;
    logic [5:0]  poke_idx;
    logic [31:0] poke_val;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) begin
                sim_mem[0][i] <= seed_word(0, i);
                sim_mem[1][i] <= seed_word(1, i);
            end
        end else begin
            if (poke_en) sim_mem[poke_d][poke_idx] <= poke_val;
            for (int d = 0; d < 2; d++)
                if (wr_v[d]) sim_mem[d][maddr_v[d][7:2]] <= wdata_v[d];
        end
        rd0 <= sim_mem[0][maddr_v[0][7:2]];
        rd1 <= {rd1[1:0], sim_mem[1][maddr_v[1][7:2]]};
    end

    // Reference model state
    logic [31:0] model_mem [2][64];
    logic [31:0] regq_model [2];
    wr_t wq[$];
    dn_t dq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT writes or signals done
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_v[d]) begin
                if (wq.size() == 0) begin
                    chk($sformatf("spurious_mem_wr_dut%0d", d), 32'(wr_v[d]), 32'h0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_dut_id", 32'(d), 32'(w.d));
                    chk("write_addr", maddr_v[d], w.addr);
                    chk("write_data", wdata_v[d], w.data);
                end
            end
            if (done_v[d]) begin
                if (dq.size() == 0) begin
                    chk($sformatf("spurious_done_dut%0d", d), 32'(done_v[d]), 32'h0);
                end else begin
                    dn_t n;
                    n = dq.pop_front();
                    chk("done_dut_id", 32'(d), 32'(n.d));
                    chk("done_cycle", 32'(cyc), 32'(n.cyc));
                    chk("done_mem_reg_q", regq_v[d], n.regq);
                end
            end
        end
    end

    function automatic int mem_lat(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    task automatic randomize_inputs(input int d);
        op_v[d]   = 2'($urandom_range(0, 3));
        addr_v[d] = 32'($urandom_range(0, 255));
        b_v[d]    = $urandom;
    endtask

    task automatic poke(input int d, input logic [31:0] a, input logic [31:0] v);
        poke_en  = 1'b1;
        poke_d   = d;
        poke_idx = a[7:2];
        poke_val = v;
        model_mem[d][a[7:2]] = v;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issue one request at a negedge while idle; returns one cycle later
    task automatic issue(input int d, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        int n = 0;
        logic [31:0] word;
        logic [31:0] data;
        int lat;
        while (busy_v[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_issue", 32'(busy_v[d]), 32'h0);
        start_v[d] = 1'b1;
        op_v[d]    = op;
        addr_v[d]  = a;
        b_v[d]     = b;
        if (push) begin
            word = model_mem[d][a[7:2]];
            data = b;
            lat  = 1;
            case (op)
                2'b01: lat = 2;
                2'b10: begin
                    lat  = mem_lat(d) + 3;
                    data = (word & 32'hFFFF0000) | (b & 32'h0000FFFF);
                    regq_model[d] = word;
                end
                2'b11: begin
                    lat  = mem_lat(d) + 3;
                    data = (word & 32'hFFFFFF00) | (b & 32'h000000FF);
                    regq_model[d] = word;
                end
                default: lat = 1;
            endcase
            if (op != 2'b00) begin
                wq.push_back('{d: d, addr: a, data: data});
                model_mem[d][a[7:2]] = data;
            end
            dq.push_back('{d: d, cyc: cyc + lat, regq: regq_model[d]});
        end
        @(negedge clk);
        start_v[d] = 1'b0;
        randomize_inputs(d);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done_v[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done_v[d]), 32'h1);
    endtask

    task automatic drain();
        int n = 0;
        while ((wq.size() != 0 || dq.size() != 0 || busy_v != 2'b00) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_empty", 32'(wq.size() + dq.size()), 32'h0);
        chk("busy_after_drain", 32'(busy_v), 32'h0);
    endtask

    task automatic check_reset_outputs(input int d);
        chk("rst_busy", 32'(busy_v[d]), 32'h0);
        chk("rst_done", 32'(done_v[d]), 32'h0);
        chk("rst_mem_wr", 32'(wr_v[d]), 32'h0);
        chk("rst_mem_addr", maddr_v[d], 32'h0);
        chk("rst_mem_wdata", wdata_v[d], 32'h0);
        chk("rst_mem_reg_q", regq_v[d], 32'h0);
    endtask

    // Asserts reset for one cycle at the current negedge
    task automatic pulse_reset(input int d);
        reset_v[d] = 1'b1;
        @(negedge clk);
        reset_v[d] = 1'b0;
        regq_model[d] = 32'h0;
        check_reset_outputs(d);
        repeat (3) @(negedge clk);
        chk("idle_after_reset", 32'(busy_v[d]), 32'h0);
    endtask

    initial begin
        reset_v  = 2'b11;
        start_v  = 2'b00;
        op_v     = '0;
        addr_v   = '0;
        b_v      = '0;
        mem_init = 1'b1;
        poke_en  = 1'b0;
        poke_d   = 0;
        poke_idx = '0;
        poke_val = '0;
        for (int d = 0; d < 2; d++) begin
            regq_model[d] = 32'h0;
            for (int i = 0; i < 64; i++) model_mem[d][i] = seed_word(d, i);
        end
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        reset_v  = 2'b00;
        check_reset_outputs(0);
        check_reset_outputs(1);

        // SW, SH, SB with known memory contents
        issue(0, 2'b01, 32'h40, 32'hDEADBEEF, 1);
        drain();
        poke(0, 32'h40, 32'h11223344);
        issue(0, 2'b10, 32'h40, 32'hAAAABBBB, 1);
        drain();
        poke(0, 32'h40, 32'h11223344);
        issue(0, 2'b11, 32'h40, 32'h000000CC, 1);
        drain();
        poke(1, 32'h40, 32'h11223344);
        issue(1, 2'b11, 32'h40, 32'h000000CC, 1);
        drain();

        // start while busy and in the done cycle is dropped; next cycle accepted
        for (int d = 0; d < 2; d++) begin
            issue(d, 2'b10, 32'h80, $urandom, 1);
            start_v[d] = 1'b1;
            op_v[d]    = 2'b01;
            @(negedge clk);
            start_v[d] = 1'b0;
            wait_done(d);
            start_v[d] = 1'b1;
            op_v[d]    = 2'b01;
            addr_v[d]  = 32'h88;
            @(negedge clk);
            issue(d, 2'b01, 32'h84, $urandom, 1);
            drain();
        end

        // reset during READ and WRITE: no write, no done
        for (int d = 0; d < 2; d++) begin
            issue(d, 2'b10, 32'h44, $urandom, 0);
            pulse_reset(d);
            issue(d, 2'b01, 32'h48, $urandom, 0);
            pulse_reset(d);
            issue(d, 2'b11, 32'h4C, $urandom, 0);
            repeat (mem_lat(d) + 1) @(negedge clk);
            pulse_reset(d);
            drain();
        end

        // NOP, then SH with inputs toggling while in flight
        issue(0, 2'b00, 32'h50, $urandom, 1);
        drain();
        issue(1, 2'b10, 32'h54, $urandom, 1);
        repeat (4) begin
            randomize_inputs(1);
            @(negedge clk);
        end
        drain();

        // Randomized traffic, occasionally with an ignored start while busy
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 30; k++) begin
                issue(d, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 255)), $urandom, 1);
                if ($urandom_range(0, 2) == 0) begin
                    start_v[d] = 1'b1;
                    @(negedge clk);
                    start_v[d] = 1'b0;
                end
            end
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_store_rmw_ctrl
`default_nettype wire
